// File: rtl/alu_pkg.sv
// alu_pkg: ALU select encoding, RV32I decode constants and the issue entry type.
package alu_pkg;
  typedef enum logic [3:0] {
    SEL_NONE, SEL_ADD, SEL_SUB, SEL_AND, SEL_OR, SEL_XOR, SEL_SRL, SEL_SRA, SEL_SLL
  } alu_sel_e;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_sel_e    sel;
    logic [4:0]  rd;
    logic        illegal;
  } issue_entry_t;
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational RV32I OP/OP-IMM decode into ALU operands and select.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic [31:0]  rs1,
  input  logic [31:0]  rs2,
  output issue_entry_t entry
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       is_op, is_imm, is_shift, unused_rs_idx;
  alu_sel_e   sel;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign is_op = opc == OPC_OP;
  assign is_imm = opc == OPC_OP_IMM;
  assign is_shift = f3 == F3_SLL || f3 == F3_SR;
  assign unused_rs_idx = ^instr[19:15];
  always_comb begin
    sel = SEL_NONE;
    if (is_op)
      case ({f7, f3})
        {F7_BASE, F3_ADD}: sel = SEL_ADD;
        {F7_ALT,  F3_ADD}: sel = SEL_SUB;
        {F7_BASE, F3_AND}: sel = SEL_AND;
        {F7_BASE, F3_OR}:  sel = SEL_OR;
        {F7_BASE, F3_XOR}: sel = SEL_XOR;
        {F7_BASE, F3_SR}:  sel = SEL_SRL;
        {F7_ALT,  F3_SR}:  sel = SEL_SRA;
        {F7_BASE, F3_SLL}: sel = SEL_SLL;
        default:           sel = SEL_NONE;
      endcase
    else if (is_imm)
      case (f3)
        F3_ADD:  sel = SEL_ADD;
        F3_AND:  sel = SEL_AND;
        F3_OR:   sel = SEL_OR;
        F3_XOR:  sel = SEL_XOR;
        F3_SLL:  sel = f7 == F7_BASE ? SEL_SLL : SEL_NONE;
        F3_SR:   sel = f7 == F7_BASE ? SEL_SRL : f7 == F7_ALT ? SEL_SRA : SEL_NONE;
        default: sel = SEL_NONE;
      endcase
  end
  always_comb begin
    entry.sel = sel;
    entry.rd = instr[11:7];
    entry.illegal = sel == SEL_NONE;
    entry.a = entry.illegal ? '0 : rs1;
    entry.b = entry.illegal ? '0 : is_op ? rs2 :
              is_shift ? {27'b0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
  end
endmodule

// File: rtl/alu_issue.sv
// alu_issue: registered ALU issue stage with 2-entry skid buffer, flush and illegal counter.
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_sel,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic [15:0]     illegal_cnt
);
  issue_entry_t dec, out_q, skid_q;
  logic acc, cons;
  alu_decode u_dec (.instr(in_instr), .rs1(in_rs1_data), .rs2(in_rs2_data), .entry(dec));
  assign acc = in_valid && in_ready;
  assign cons = out_valid && out_ready;
  assign out_a = out_q.a;
  assign out_b = out_q.b;
  assign out_sel = out_q.sel;
  assign out_rd = out_q.rd;
  assign out_illegal = out_q.illegal;
  // in_ready doubles as the skid-empty flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      in_ready <= 1'b1;
      out_q <= '0;
      skid_q <= '0;
      illegal_cnt <= '0;
    end else begin
      if (cons && out_q.illegal && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 16'd1;
      if (flush) begin
        out_valid <= 1'b0;
        in_ready <= 1'b1;
      end else if (!out_valid || out_ready) begin
        out_valid <= !in_ready || acc;
        in_ready <= 1'b1;
        if (!in_ready) out_q <= skid_q;
        else if (acc) out_q <= dec;
      end else if (acc) begin
        skid_q <= dec;
        in_ready <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors with a scoreboard queue checked by a negedge monitor.
module tb_alu_issue;
  import alu_pkg::*;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_instr = 0, in_rs1_data = 0, in_rs2_data = 0;
  logic in_ready, out_valid, out_illegal;
  logic [31:0] out_a, out_b;
  logic [3:0] out_sel;
  logic [4:0] out_rd;
  logic [15:0] illegal_cnt;
  int tests = 0, fails = 0, exp_cnt = 0;
  issue_entry_t exp_q[$];
  issue_entry_t cur_exp, e;
  logic [73:0] got, held;
  logic stalled = 0;
  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_sel(out_sel), .out_rd(out_rd), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [79:0] act, logic [79:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  function automatic issue_entry_t ent(logic [31:0] a, logic [31:0] b, logic [3:0] s, logic [4:0] rd, logic il);
    ent = '{a: a, b: b, sel: alu_sel_e'(s), rd: rd, illegal: il};
  endfunction
  task automatic send(logic [31:0] i, logic [31:0] r1, logic [31:0] r2, issue_entry_t x);
    bit took = 0;
    in_instr = i;
    in_rs1_data = r1;
    in_rs2_data = r2;
    cur_exp = x;
    in_valid = 1;
    for (int k = 0; k < 20 && !took; k++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    if (!took) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: instr %08h not accepted within 20 cycles", i);
    end
    in_valid = 0;
  endtask
  always @(negedge clk) begin
    got = {out_a, out_b, out_sel, out_rd, out_illegal};
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
      stalled = 0;
    end else begin
      chk("illegal_cnt", 80'(illegal_cnt), 80'(exp_cnt));
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL issue: unexpected entry %0h with empty scoreboard", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            fails++;
            $display("FAIL issue: got %0h expected %0h", got, e);
          end
          if (e.illegal) exp_cnt++;
        end
      end
      if (out_valid && !out_ready) begin
        if (stalled) chk("stall_hold", 80'(got), 80'(held));
        held = got;
        stalled = 1;
      end else stalled = 0;
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 80'(out_valid), 0);
    chk("rst_in_ready", 80'(in_ready), 1);
    chk("rst_cnt", 80'(illegal_cnt), 0);
    chk("rst_fields", 80'({out_a, out_b, out_sel, out_rd, out_illegal}), 0);
    rst_n = 1;
    send(32'h002081B3, 5, 7, ent(5, 7, 1, 3, 0));
    chk("lat_valid", 80'(out_valid), 1);
    chk("lat_entry", 80'({out_a, out_b, out_sel, out_rd, out_illegal}), 80'(ent(5, 7, 1, 3, 0)));
    send(32'h402081B3, 9, 4, ent(9, 4, 2, 3, 0));
    send(32'hFFF00293, 0, 32'h1234, ent(0, 32'hFFFFFFFF, 1, 5, 0));
    send(32'h4040D313, 32'h80000000, 32'h55, ent(32'h80000000, 4, 7, 6, 0));
    send(32'h0020A1B3, 5, 7, ent(0, 0, 0, 3, 1));
    @(posedge clk);
    #1;
    chk("cnt_after_slt", 80'(illegal_cnt), 1);
    send(32'h022081B3, 3, 4, ent(0, 0, 0, 3, 1));
    send(32'h000002B7, 3, 4, ent(0, 0, 0, 5, 1));
    send(32'h2040D313, 3, 4, ent(0, 0, 0, 6, 1));
    send(32'h0020F1B3, 32'hF0F0, 32'hFF00, ent(32'hF0F0, 32'hFF00, 3, 3, 0));
    send(32'h0020E1B3, 32'hF0F0, 32'hFF00, ent(32'hF0F0, 32'hFF00, 4, 3, 0));
    send(32'h0020C1B3, 32'hF0F0, 32'hFF00, ent(32'hF0F0, 32'hFF00, 5, 3, 0));
    send(32'h0020D1B3, 32'h100, 4, ent(32'h100, 4, 6, 3, 0));
    send(32'h002091B3, 32'h100, 4, ent(32'h100, 4, 8, 3, 0));
    send(32'h01F09393, 1, 32'hDEAD, ent(1, 31, 8, 7, 0));
    send(32'h0F00F293, 32'hABCD, 0, ent(32'hABCD, 32'hF0, 3, 5, 0));
    send(32'hFFE0E293, 32'h10, 9, ent(32'h10, 32'hFFFFFFFE, 4, 5, 0));
    send(32'h0010B293, 32'h10, 9, ent(0, 0, 0, 5, 1));
    repeat (3) @(posedge clk);
    #1;
    chk("drained", 80'(exp_q.size()), 0);
    chk("cnt_five", 80'(illegal_cnt), 5);
    out_ready = 0;
    send(32'h002081B3, 1, 2, ent(1, 2, 1, 3, 0));
    chk("bp_ready_hi", 80'(in_ready), 1);
    send(32'h402081B3, 10, 3, ent(10, 3, 2, 3, 0));
    chk("bp_ready_lo", 80'(in_ready), 0);
    @(posedge clk);
    #1;
    chk("bp_still_held", 80'({out_a, out_b, out_sel}), 80'({32'd1, 32'd2, 4'd1}));
    out_ready = 1;
    send(32'h0020F1B3, 6, 3, ent(6, 3, 3, 3, 0));
    send(32'h0020C1B3, 6, 3, ent(6, 3, 5, 3, 0));
    repeat (3) @(posedge clk);
    #1;
    chk("bp_drained", 80'(exp_q.size()), 0);
    out_ready = 0;
    send(32'h002081B3, 11, 12, ent(11, 12, 1, 3, 0));
    send(32'h002081B3, 13, 14, ent(13, 14, 1, 3, 0));
    in_instr = 32'h402081B3;
    cur_exp = ent(15, 16, 2, 3, 0);
    in_valid = 1;
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    in_valid = 0;
    chk("flush_valid", 80'(out_valid), 0);
    chk("flush_ready", 80'(in_ready), 1);
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_idle", 80'(out_valid), 0);
    send(32'h000002B7, 0, 0, ent(0, 0, 0, 5, 1));
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    chk("flush_consume_cnt", 80'(illegal_cnt), 6);
    chk("flush_consume_valid", 80'(out_valid), 0);
    out_ready = 0;
    send(32'h002081B3, 1, 1, ent(1, 1, 1, 3, 0));
    send(32'h002081B3, 2, 2, ent(2, 2, 1, 3, 0));
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 80'(out_valid), 0);
    chk("mid_rst_ready", 80'(in_ready), 1);
    chk("mid_rst_cnt", 80'(illegal_cnt), 0);
    chk("mid_rst_fields", 80'({out_a, out_b, out_sel, out_rd, out_illegal}), 0);
    rst_n = 1;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_idle", 80'(out_valid), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Issue stage between instruction decode and the 32-bit ALU. Accepts RV32I register-register (OP) and register-immediate (OP-IMM) instructions with their source-register data, and decodes them into the ALU's operand/select encoding. It registers the result and presents it to the execute side through a valid/ready handshake. A 2-entry skid buffer keeps full throughput under back-pressure, and a synchronous flush squashes in-flight entries on redirect.

## Interface
Parameters:
- XLEN, 32, operand width; only 32 is supported.

Ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_rs1_data  in  XLEN  rs1 value.
- in_rs2_data  in  XLEN  rs2 value.
- out_valid  out  1  entry presented to ALU/execute.
- out_ready  in  1  execute consumes this cycle.
- out_a  out  XLEN  ALU operand A.
- out_b  out  XLEN  ALU operand B.
- out_sel  out  4  ALU select.
- out_rd  out  5  destination register.
- out_illegal  out  1  instruction not executable by the ALU.
- illegal_cnt  out  16  saturating count of illegal instructions issued.

## Operation
- ALU select codes: 0 none, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 srl, 7 sra, 8 sll.
- OP (opcode 0110011), decoded on funct7/funct3:
  - 0000000/000 add, 0100000/000 sub.
  - 0000000/111 and, 0000000/110 or, 0000000/100 xor.
  - 0000000/101 srl, 0100000/101 sra, 0000000/001 sll.
  - A = rs1, B = rs2.
- OP-IMM (0010011): addi, andi, ori, xori map to 1/3/4/5 with B = sign-extended imm[31:20].
  - slli requires imm[11:5]=0000000; srli requires 0000000; srai requires 0100000.
  - For shifts, B = zero-extended shamt (instr[24:20]).
- Illegal cases: slt/sltu/slti/sltiu, any other funct7 (including M-extension 0000001), and any other opcode.
  - Illegal entries still issue in order, with out_illegal=1, sel=0, a=b=0, rd=instr[11:7].
- rd=x0 decodes normally; suppressing the write is done downstream.
- illegal_cnt increments when an illegal entry is consumed (out_valid && out_ready). It saturates at 0xFFFF and is not cleared by flush.

## Timing
- Reset (rst_n=0 at a clock edge):
  - out_valid=0, in_ready=1, skid empty, illegal_cnt=0.
  - out_a/out_b/out_rd=0, out_sel=0, out_illegal=0.
- Latency: an instruction accepted at edge N is presented with out_valid=1 after edge N (one cycle).
- Throughput: one instruction per cycle while out_ready=1.
- Acceptance occurs on in_valid && in_ready.
  - in_ready is a register: 1 iff the skid entry is empty.
  - It never depends combinationally on out_ready.
- Stall: if the output entry is held (out_valid && !out_ready) and an input is accepted, the input goes to the skid entry and in_ready drops the next cycle.
  - When the output is consumed, skid moves to output and in_ready rises.
- Simultaneous consume and accept with skid empty: the new entry replaces the output directly, with no bubble.
- Output holds stable (all out_* fields) while out_valid && !out_ready.
- Flush:
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - An instruction offered in the flush cycle is dropped.
  - A consume in the flush cycle still counts for illegal_cnt.
- Reset has priority over flush. Reset mid-stall discards both entries.

## Structure
- Package alu_pkg:
  - alu_sel_e enum (NONE..SLL with the codes above), shared with the ALU.
  - OPC_OP/OPC_OP_IMM opcode constants.
  - funct3/funct7 constants.
  - issue_entry_t struct {a, b, sel, rd, illegal}.
- Sub-module alu_decode: purely combinational, instr + rs1/rs2 -> issue_entry_t.
- The top holds the output register, skid register, and counter.

## Test plan
- Reset, then add x3,x1,x2 (0x002081B3) with rs1=5, rs2=7.
  - Expect: next cycle out_valid=1, a=5, b=7, sel=1, rd=3, illegal=0.
- sub 0x402081B3 -> sel=2.
- addi x5,x0,-1 (0xFFF00293) with rs1=0 -> b=0xFFFFFFFF, sel=1, rd=5.
- srai x6,x1,4 (0x4040D313) with rs1=0x80000000 -> sel=7, b=4, rd=6.
- slt 0x0020A1B3 -> out_illegal=1, sel=0, a=b=0. illegal_cnt=1 after consume.
- Back-pressure: stream 4 instructions with out_ready low for 3 cycles.
  - Expect: in_ready drops after the 2nd accept.
  - No loss or duplication, order preserved, output stable while stalled.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing issued from that cycle.
